// File: rtl/coproc_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coproc_host_pkg
// Description : Shared opcodes, bus request codes, FSM states and latencies
//               for the coprocessor host slice.
// Revision    : 1.0
// ============================================================================
package coproc_host_pkg;

    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;

    localparam logic [3:0] REQ_NEXT = 4'b0011;
    localparam logic [3:0] REQ_DATA = 4'b0001;

    localparam int DEF_LAT_ADDI = 6;
    localparam int DEF_LAT_ADD  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic is_supported(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_ADD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/coproc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : coproc_regfile
// Description : 4x4-bit register file, one write port, a host read port and
//               an operand read port for the coprocessor bus.
// Revision    : 1.0
// ============================================================================
module coproc_regfile
    import coproc_host_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [1:0] rd_addr,
    output logic [3:0] rd_data,
    input  logic [1:0] op_addr,
    output logic [3:0] op_data
);

    logic [3:0] r_mem [0:3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 4'd0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Reads see the pre-write contents during a write cycle.
    assign rd_data = r_mem[rd_addr];
    assign op_data = r_mem[op_addr];

endmodule
`default_nettype wire

// File: rtl/coproc_host.sv
`default_nettype none
// ============================================================================
// Module      : coproc_host
// Description : Issues ADDI/ADD to an external coprocessor, serves operands
//               over its request bus and captures the result after a fixed
//               latency.
// Revision    : 1.0
// ============================================================================
module coproc_host
    import coproc_host_pkg::*;
#(
    parameter int LAT_ADDI = DEF_LAT_ADDI,
    parameter int LAT_ADD  = DEF_LAT_ADD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [3:0] instr_imm,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs1,
    input  logic [1:0] instr_rs2,
    output logic       resp_valid,
    output logic       resp_err,
    output logic [3:0] resp_data,
    output logic       resp_carry,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [1:0] rd_addr,
    output logic [3:0] rd_data,
    output logic       cp_rst_n,
    output logic [3:0] cp_opcode,
    output logic [3:0] cp_imm,
    input  logic [3:0] cp_bus_req,
    input  logic [3:0] cp_bus_in,
    output logic [3:0] cp_bus_out,
    output logic       cp_bus_oe,
    output logic       cp_oe_n,
    input  logic       cp_carry
);

    // Capture happens on the edge where the counter would reach the latency.
    localparam logic [3:0] c_addi_last = 4'(LAT_ADDI - 1);
    localparam logic [3:0] c_add_last  = 4'(LAT_ADD - 1);

    state_t     r_state;
    state_t     w_state_next;

    logic       w_accept;
    logic       w_start;
    logic       w_capture;
    logic       w_rf_we;
    logic [1:0] w_rf_addr;
    logic [3:0] w_rf_data;
    logic [1:0] w_op_addr;
    logic [3:0] w_op_data;

    logic [3:0] r_op;
    logic [3:0] r_imm;
    logic [1:0] r_rd;
    logic [1:0] r_rs1;
    logic [1:0] r_rs2;
    logic       r_idx;
    logic [3:0] r_cnt;
    logic       r_carry;
    logic       r_cp_rst_n;
    logic [3:0] r_cp_opcode;
    logic       r_resp_valid;
    logic       r_resp_err;
    logic [3:0] r_resp_data;

    assign instr_ready = (r_state == IDLE);
    assign w_accept    = instr_valid && instr_ready;
    assign w_start     = w_accept && is_supported(instr_op);
    assign w_capture   = (r_state == RUN) &&
                         (r_cnt == ((r_op == OP_ADD) ? c_add_last : c_addi_last));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start)   w_state_next = SYNC;
            SYNC:                   w_state_next = RUN;
            RUN:     if (w_capture) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op         <= 4'd0;
            r_imm        <= 4'd0;
            r_rd         <= 2'd0;
            r_rs1        <= 2'd0;
            r_rs2        <= 2'd0;
            r_idx        <= 1'b0;
            r_cnt        <= 4'd0;
            r_carry      <= 1'b0;
            r_cp_rst_n   <= 1'b1;
            r_cp_opcode  <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= 4'd0;
        end else begin
            r_resp_valid <= 1'b0;
            r_cp_rst_n   <= (w_state_next != SYNC);

            if (w_accept) begin
                r_op  <= instr_op;
                r_imm <= instr_imm;
                r_rd  <= instr_rd;
                r_rs1 <= instr_rs1;
                r_rs2 <= instr_rs2;
                r_idx <= 1'b0;
            end

            if (w_accept && !w_start) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
            end

            if (r_state == SYNC) begin
                r_cnt       <= 4'd0;
                r_cp_opcode <= r_op;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + 4'd1;
                if (cp_bus_req == REQ_NEXT) begin
                    r_idx <= 1'b1;
                end
                if (w_capture) begin
                    r_cp_opcode  <= 4'd0;
                    r_carry      <= cp_carry;
                    r_resp_data  <= cp_bus_in;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                end
            end
        end
    end

    // Host writes and result capture never coincide: one needs IDLE, the other RUN.
    assign w_rf_we   = w_capture || (wr_en && instr_ready && !w_accept);
    assign w_rf_addr = w_capture ? r_rd : wr_addr;
    assign w_rf_data = w_capture ? cp_bus_in : wr_data;

    // ADD serves rs2 first, then rs1 once the coprocessor has asked for the next operand.
    assign w_op_addr = (!r_idx && (r_op == OP_ADD)) ? r_rs2 : r_rs1;

    coproc_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_rf_we),
        .wr_addr (w_rf_addr),
        .wr_data (w_rf_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .op_addr (w_op_addr),
        .op_data (w_op_data)
    );

    assign cp_rst_n   = r_cp_rst_n;
    assign cp_opcode  = r_cp_opcode;
    assign cp_imm     = (r_cp_opcode != 4'd0) ? r_imm : 4'd0;
    assign cp_oe_n    = (r_state != RUN);
    assign cp_bus_oe  = (r_state == RUN) && (cp_bus_req == REQ_DATA);
    assign cp_bus_out = cp_bus_oe ? w_op_data : 4'd0;

    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_data  = r_resp_data;
    assign resp_carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_coproc_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_coproc_host
// Description : Directed bench for coproc_host with a cycle-accurate
//               coprocessor model on the request bus.
// Revision    : 1.0
// ============================================================================
module tb_coproc_host;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [3:0] instr_imm;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic [1:0] instr_rs2;
    logic       resp_valid;
    logic       resp_err;
    logic [3:0] resp_data;
    logic       resp_carry;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       cp_rst_n;
    logic [3:0] cp_opcode;
    logic [3:0] cp_imm;
    logic [3:0] cp_bus_req;
    logic [3:0] cp_bus_in;
    logic [3:0] cp_bus_out;
    logic       cp_bus_oe;
    logic       cp_oe_n;
    logic       cp_carry;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    coproc_host dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_imm   (instr_imm),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_data   (resp_data),
        .resp_carry  (resp_carry),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cp_rst_n    (cp_rst_n),
        .cp_opcode   (cp_opcode),
        .cp_imm      (cp_imm),
        .cp_bus_req  (cp_bus_req),
        .cp_bus_in   (cp_bus_in),
        .cp_bus_out  (cp_bus_out),
        .cp_bus_oe   (cp_bus_oe),
        .cp_oe_n     (cp_oe_n),
        .cp_carry    (cp_carry)
    );

    // Coprocessor model: mk counts RUN cycles. Operand fetch at mk 1 (and ADD:
    // NEXT at 2, second fetch at 3); result driven only in the last cycle.
    int         mk;
    int         nd;
    logic [3:0] md0;
    logic [3:0] md1;
    logic [4:0] msum;

    always @(negedge clk) begin
        cp_bus_req = 4'd0;
        cp_bus_in  = 4'd0;
        cp_carry   = 1'b0;
        if (cp_oe_n) begin
            mk = 0;
            nd = 0;
        end else begin
            if (mk == 1 || (cp_opcode == 4'd2 && mk == 3)) cp_bus_req = 4'b0001;
            if (cp_opcode == 4'd2 && mk == 2)              cp_bus_req = 4'b0011;
            if (mk == ((cp_opcode == 4'd2) ? 6 : 5)) begin
                msum = (cp_opcode == 4'd2) ? ({1'b0, md0} + {1'b0, md1})
                                           : ({1'b0, cp_imm} + {1'b0, md0});
                cp_bus_in = msum[3:0];
                cp_carry  = msum[4];
            end
            mk++;
            if (cp_bus_req == 4'b0001) begin
                #1;
                if (nd == 0) md0 = cp_bus_out;
                else         md1 = cp_bus_out;
                nd++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [3:0] d);
        @(negedge clk);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    // lat = edges from acceptance to the one that raised resp_valid (-1 on timeout).
    task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [3:0] imm, input logic inject,
                             output int lat, output int rst_low, output int busy_viol);
        lat = -1; rst_low = 0; busy_viol = 0;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd;
        instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        @(posedge clk);
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == 1) instr_valid = 1'b0;
            if (inject && j == 3) begin wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'd15; end
            if (inject && j == 4) wr_en = 1'b0;
            if (!cp_rst_n) rst_low++;
            if (resp_valid) begin
                lat = j - 1;
                break;
            end
            if (instr_ready) busy_viol++;
        end
        wr_en = 1'b0;
    endtask

    logic [3:0] v0, v1, v2, v3;
    int lat, rlow, busy, cnt;

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 4'd0; instr_imm = 4'd0;
        instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0; rd_addr = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", instr_ready, 1);
        check("rst_cp_rst_n", cp_rst_n, 1);
        check("rst_cp_oe_n", cp_oe_n, 1);
        check("rst_resp", {resp_valid, resp_err, resp_carry, resp_data}, 0);
        check("rst_cp_out", {cp_opcode, cp_imm, cp_bus_oe, cp_bus_out}, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        // Write R1=3 while reading it: old value first, new value after the edge.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'd3; rd_addr = 2'd1;
        #1 check("rd_during_wr_old", rd_data, 0);
        @(negedge clk);
        wr_en = 1'b0;
        #1 check("rd_after_wr", rd_data, 3);

        run_instr(4'd1, 2'd2, 2'd1, 2'd0, 4'd5, 1'b0, lat, rlow, busy);
        check("addi_lat", lat, 7);
        check("addi_cp_rst_low", rlow, 1);
        check("addi_resp", {resp_err, resp_carry, resp_data}, {1'b0, 1'b0, 4'd8});
        check("addi_operand", md0, 3);
        @(negedge clk);
        check("addi_pulse_hold", {resp_valid, resp_data}, {1'b0, 4'd8});
        reg_read(2'd2, v2);
        check("addi_r2", v2, 8);

        reg_write(2'd0, 4'd9);
        reg_write(2'd3, 4'd9);
        run_instr(4'd2, 2'd1, 2'd0, 2'd3, 4'd0, 1'b1, lat, rlow, busy);
        check("add_lat", lat, 8);
        check("add_busy", busy, 0);
        check("add_resp", {resp_err, resp_carry, resp_data}, {1'b0, 1'b1, 4'd2});
        check("add_operands", {md0, md1}, {4'd9, 4'd9});
        reg_read(2'd1, v1);
        check("add_r1", v1, 2);
        reg_read(2'd3, v3);
        check("add_wr_ignored_r3", v3, 9);

        // Distinct operands expose the rs2-then-rs1 order: R2=8, R1=2.
        run_instr(4'd2, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, lat, rlow, busy);
        check("add2_order", {md0, md1}, {4'd2, 4'd8});
        check("add2_resp", {resp_carry, resp_data}, {1'b0, 4'd10});

        run_instr(4'd7, 2'd3, 2'd0, 2'd0, 4'd0, 1'b0, lat, rlow, busy);
        check("bad_lat", lat, 0);
        check("bad_err", resp_err, 1);
        cnt = rlow;
        repeat (4) begin
            @(negedge clk);
            if (!cp_rst_n) cnt++;
        end
        check("bad_cp_rst_n", cnt, 0);
        reg_read(2'd0, v0); reg_read(2'd1, v1); reg_read(2'd2, v2); reg_read(2'd3, v3);
        check("bad_regs", {v0, v1, v2, v3}, {4'd10, 4'd2, 4'd8, 4'd9});

        // Reset while the counter sits at 3 in an ADDI.
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'd1; instr_rd = 2'd2; instr_rs1 = 2'd1; instr_imm = 4'd5;
        @(posedge clk);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 1) instr_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", {instr_ready, cp_rst_n, cp_oe_n, cp_opcode}, {3'b111, 4'd0});
        rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        check("midrst_no_resp", cnt, 0);
        reg_read(2'd2, v2);
        check("midrst_r2", v2, 0);

        reg_write(2'd1, 4'd3);
        run_instr(4'd1, 2'd2, 2'd1, 2'd0, 4'd5, 1'b0, lat, rlow, busy);
        check("readdi_lat", lat, 7);
        check("readdi_resp", {resp_err, resp_carry, resp_data}, {1'b0, 1'b0, 4'd8});
        reg_read(2'd2, v2);
        check("readdi_r2", v2, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
